// File: rtl/audio_nios_sram_pipe.sv
// Avalon-MM word SRAM for the audio/Nios subsystem: clock-enabled, 1- or 2-cycle
// read pipeline, byte-enabled writes and a background zero-fill engine.
module audio_nios_sram_pipe #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 80000,
    parameter int ADDR_W         = 17,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                init_req,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                init_busy
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    state_t                                state, state_next;
    logic [ADDR_W-1:0]                     clr_addr, clr_addr_next;
    logic                                  clear_pending, clear_pending_next;
    logic [DATA_W-1:0]                     mem [DEPTH];
    logic [READ_LATENCY-1:0]               pipe_valid;
    logic [READ_LATENCY-1:0][DATA_W-1:0]   pipe_data;
    logic [IDX_W-1:0]                      idx, clr_idx;
    logic [DATA_W-1:0]                     rd_word, wr_word;
    logic                                  in_range, accept, wr_accept, rd_accept, in_flight;

    assign in_range      = {1'b0, address} < DEPTH_EXT;
    assign idx           = address[IDX_W-1:0];
    assign clr_idx       = clr_addr[IDX_W-1:0];
    assign waitrequest   = ~reset_n | ~clken | (state != READY) | clear_pending;
    assign accept        = chipselect & (read | write) & ~waitrequest & clken;
    assign wr_accept     = accept & write & in_range;
    assign rd_accept     = accept & read & ~write;
    assign in_flight     = |pipe_valid;
    assign rd_word       = in_range ? mem[idx] : '0;
    assign init_busy     = (state == CLEAR);
    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_valid[READ_LATENCY-1];

    always_comb begin
        wr_word = mem[idx];
        for (int b = 0; b < BYTES; b++) begin
            if (byteenable[b]) wr_word[8*b +: 8] = writedata[8*b +: 8];
        end
    end

    // The zero-fill engine owns the write port whenever the FSM is clearing.
    always_ff @(posedge clk) begin
        if (clken) begin
            if (state == CLEAR) mem[clr_idx] <= '0;
            else if (wr_accept) mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_data  <= '0;
        end else if (clken) begin
            pipe_valid[0] <= rd_accept;
            pipe_data[0]  <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RESET_STATE;
            clr_addr      <= '0;
            clear_pending <= 1'b0;
        end else if (clken) begin
            state         <= state_next;
            clr_addr      <= clr_addr_next;
            clear_pending <= clear_pending_next;
        end
    end

    // A requested clear waits for outstanding reads so none return zero-filled data.
    always_comb begin
        state_next         = state;
        clr_addr_next      = clr_addr;
        clear_pending_next = clear_pending;
        case (state)
            CLEAR: begin
                clr_addr_next = clr_addr + ADDR_W'(1);
                if (clr_addr == LAST_ADDR) state_next = READY;
            end
            READY: begin
                if (clear_pending && !in_flight) begin
                    state_next         = CLEAR;
                    clr_addr_next      = '0;
                    clear_pending_next = 1'b0;
                end else if (init_req) begin
                    clear_pending_next = 1'b1;
                end
            end
            default: state_next = READY;
        endcase
    end
endmodule

// File: tb/tb_audio_nios_sram_pipe.sv
// Randomized self-checking bench: two 16-word instances (latency 1 and 2) share one bus
// against a queue-based reference model; a full-size instance covers the out-of-range case.
module tb_audio_nios_sram_pipe;
    logic        clk = 1'b0;
    logic        reset_n, clken, chipselect, read, write, init_req;
    logic [4:0]  address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata [2];
    logic        readdatavalid [2];
    logic        waitrequest [2];
    logic        init_busy [2];

    logic        c_chipselect, c_read, c_write;
    logic [16:0] c_address;
    logic [3:0]  c_byteenable;
    logic [31:0] c_writedata, c_readdata;
    logic        c_rdv, c_wait, c_busy;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    logic [31:0] mmem [2][16];
    bit          m_busy [2];
    int          m_clr [2];
    bit          m_pend [2];
    rd_t         rq [2][$];
    int          ecyc;
    int          n_checks = 0;
    int          n_fails = 0;

    always #5 clk = ~clk;

    audio_nios_sram_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect), .read(read),
        .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
        .init_req(init_req), .readdata(readdata[0]), .readdatavalid(readdatavalid[0]),
        .waitrequest(waitrequest[0]), .init_busy(init_busy[0]));

    audio_nios_sram_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect), .read(read),
        .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
        .init_req(init_req), .readdata(readdata[1]), .readdatavalid(readdatavalid[1]),
        .waitrequest(waitrequest[1]), .init_busy(init_busy[1]));

    audio_nios_sram_pipe #(.DATA_W(32), .DEPTH(80000), .ADDR_W(17), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut_c (
        .clk(clk), .reset_n(reset_n), .clken(1'b1), .chipselect(c_chipselect), .read(c_read),
        .write(c_write), .address(c_address), .byteenable(c_byteenable), .writedata(c_writedata),
        .init_req(1'b0), .readdata(c_readdata), .readdatavalid(c_rdv),
        .waitrequest(c_wait), .init_busy(c_busy));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b1;
            m_clr[d]  = 0;
            m_pend[d] = 1'b0;
            rq[d].delete();
        end
        ecyc = 0;
    endtask

    // One bus cycle: drive inputs, check the visible outputs, then advance the model across the edge.
    task automatic applyStimulus(input bit cs, input bit rd, input bit wr, input logic [4:0] a,
                                 input logic [3:0] be, input logic [31:0] wd, input bit ir, input bit ce);
        bit          exp_v, acc, busy_wait, inflight;
        logic [31:0] exp_d;
        chipselect = cs; read = rd; write = wr; address = a;
        byteenable = be; writedata = wd; init_req = ir; clken = ce;
        #1;
        for (int d = 0; d < 2; d++) begin
            busy_wait = m_busy[d] || m_pend[d];
            exp_v = (rq[d].size() > 0) && (rq[d][0].due == ecyc);
            exp_d = exp_v ? rq[d][0].data : 32'h0;
            checkOutput($sformatf("waitrequest[%0d]", d), {31'b0, waitrequest[d]}, {31'b0, !ce || busy_wait});
            checkOutput($sformatf("init_busy[%0d]", d), {31'b0, init_busy[d]}, {31'b0, m_busy[d]});
            checkOutput($sformatf("readdatavalid[%0d]", d), {31'b0, readdatavalid[d]}, {31'b0, exp_v});
            if (exp_v) checkOutput($sformatf("readdata[%0d]", d), readdata[d], exp_d);
        end
        if (ce) begin
            for (int d = 0; d < 2; d++) begin
                busy_wait = m_busy[d] || m_pend[d];
                acc = cs && (rd || wr) && !busy_wait;
                inflight = 1'b0;
                foreach (rq[d][i]) if (rq[d][i].due >= ecyc) inflight = 1'b1;
                while (rq[d].size() > 0 && rq[d][0].due <= ecyc) void'(rq[d].pop_front());
                if (acc && rd && !wr) rq[d].push_back('{(a < 16) ? mmem[d][a[3:0]] : 32'h0, ecyc + d + 1});
                if (acc && wr && a < 16) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mmem[d][a[3:0]][8*b +: 8] = wd[8*b +: 8];
                end
                if (m_busy[d]) begin
                    mmem[d][m_clr[d]] = 32'h0;
                    if (m_clr[d] == 15) m_busy[d] = 1'b0;
                    else m_clr[d]++;
                end else if (m_pend[d] && !inflight) begin
                    m_busy[d] = 1'b1;
                    m_clr[d]  = 0;
                    m_pend[d] = 1'b0;
                end else if (ir) begin
                    m_pend[d] = 1'b1;
                end
            end
            ecyc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 5'd0, 4'h0, 32'h0, 0, 1);
    endtask

    task automatic readReq(input logic [4:0] a);
        applyStimulus(1, 1, 0, a, 4'hF, 32'h0, 0, 1);
    endtask

    task automatic writeReq(input logic [4:0] a, input logic [3:0] be, input logic [31:0] wd);
        applyStimulus(1, 0, 1, a, be, wd, 0, 1);
    endtask

    task automatic checkReset(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s_rdv[%0d]", tag, d), {31'b0, readdatavalid[d]}, 32'h0);
            checkOutput($sformatf("%s_rdata[%0d]", tag, d), readdata[d], 32'h0);
            checkOutput($sformatf("%s_wait[%0d]", tag, d), {31'b0, waitrequest[d]}, 32'h1);
            checkOutput($sformatf("%s_busy[%0d]", tag, d), {31'b0, init_busy[d]}, 32'h1);
        end
    endtask

    // Counts cycles with init_busy high after reset release; a full clear spans 16 of them.
    task automatic countClear(input string tag);
        int n_a, n_b;
        n_a = 0; n_b = 0;
        for (int k = 0; k < 30; k++) begin
            if (init_busy[0]) n_a++;
            if (init_busy[1]) n_b++;
            idle(1);
        end
        checkOutput({tag, "_len_a"}, n_a, 16);
        checkOutput({tag, "_len_b"}, n_b, 16);
    endtask

    task automatic cAccess(input bit is_wr, input logic [16:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        c_chipselect = 1'b1; c_read = !is_wr; c_write = is_wr;
        c_address = a; c_writedata = wd; c_byteenable = 4'hF;
        #1 checkOutput("c_wait", {31'b0, c_wait}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        c_chipselect = 1'b0; c_read = 1'b0; c_write = 1'b0;
        #1 checkOutput("c_rdv", {31'b0, c_rdv}, {31'b0, !is_wr});
        if (!is_wr) checkOutput("c_rdata", c_readdata, exp_rd);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit reached;
        reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0; init_req = 1'b0;
        c_chipselect = 1'b0; c_read = 1'b0; c_write = 1'b0;
        c_address = '0; c_byteenable = '0; c_writedata = '0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mmem[d][i] = 32'h0;
        modelReset();

        @(negedge clk);
        #1;
        checkReset("rst0");
        checkOutput("c_rst_busy", {31'b0, c_busy}, 32'h0);
        checkOutput("c_rst_wait", {31'b0, c_wait}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        countClear("init_clear");

        readReq(5'd5);
        idle(3);

        writeReq(5'd3, 4'b0101, 32'hAABBCCDD);
        readReq(5'd3);
        idle(3);

        readReq(5'd0);
        readReq(5'd1);
        applyStimulus(1, 1, 0, 5'd2, 4'hF, 32'h0, 0, 0);
        readReq(5'd2);
        idle(4);

        writeReq(5'd0, 4'hF, 32'h11112222);
        writeReq(5'd15, 4'hF, 32'h33334444);
        writeReq(5'd16, 4'hF, 32'h12345678);
        readReq(5'd16);
        readReq(5'd0);
        readReq(5'd15);
        applyStimulus(1, 1, 1, 5'd15, 4'hF, 32'hDEADBEEF, 0, 1);
        readReq(5'd15);
        idle(3);

        readReq(5'd0);
        applyStimulus(1, 1, 0, 5'd15, 4'hF, 32'h0, 1, 1);
        readReq(5'd3);
        idle(24);
        for (int i = 0; i < 16; i++) readReq(5'(i));
        idle(3);

        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                          5'($urandom_range(0, 31)), 4'($urandom), $urandom,
                          ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0));
        end
        idle(40);

        applyStimulus(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 1);
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (m_busy[0] && m_clr[0] == 7) reached = 1'b1;
            else idle(1);
        end
        checkOutput("reach_clr7", {31'b0, reached}, 32'h1);
        chipselect = 1'b0; read = 1'b0; write = 1'b0; init_req = 1'b0;
        reset_n = 1'b0;
        #1;
        checkReset("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        countClear("restart_clear");
        for (int i = 0; i < 16; i++) readReq(5'(i));
        idle(3);

        cAccess(1'b1, 17'd0, 32'hA5A50001, 32'h0);
        cAccess(1'b1, 17'd79999, 32'h5A5AFFFF, 32'h0);
        cAccess(1'b1, 17'd80000, 32'h12345678, 32'h0);
        cAccess(1'b0, 17'd80000, 32'h0, 32'h0);
        cAccess(1'b0, 17'd0, 32'h0, 32'hA5A50001);
        cAccess(1'b0, 17'd79999, 32'h0, 32'h5A5AFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
